// File: rtl/cim_result_arbiter.sv
// cim_result_arbiter: merges two PE result streams onto one memory write port.
// Per-source FIFOs, round-robin grant, registered valid/ready output stage.
//
// Ports:
//   clk, reset (async, active-low)
//   pe0_valid_i/pe0_addr_i/pe0_tile_i : source 0 result pulse, no backpressure
//   pe1_valid_i/pe1_addr_i/pe1_tile_i : source 1 result pulse, no backpressure
//   mem_valid_o/mem_ready_i           : write handshake to memory
//   mem_addr_o/mem_tile_o/mem_src_o   : write request payload and its source
//   ovf_o                             : sticky per-source drop flags
//   idle_o                            : nothing buffered or in flight
//   wr_cnt0_o/wr_cnt1_o               : accepted-write counters
//
// Optional feature: define CIM_RESULT_ARB_STATS_EN to build the write
// counters; otherwise they are tied to zero.
module cim_result_arbiter #(
    parameter int TILE_W = 432,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pe0_valid_i,
    input  logic [ADDR_W-1:0] pe0_addr_i,
    input  logic [TILE_W-1:0] pe0_tile_i,
    input  logic              pe1_valid_i,
    input  logic [ADDR_W-1:0] pe1_addr_i,
    input  logic [TILE_W-1:0] pe1_tile_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [TILE_W-1:0] mem_tile_o,
    output logic              mem_src_o,
    output logic [1:0]        ovf_o,
    output logic              idle_o,
    output logic [15:0]       wr_cnt0_o,
    output logic [15:0]       wr_cnt1_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [1:0]             in_valid;
    logic [1:0][ADDR_W-1:0] in_addr;
    logic [1:0][TILE_W-1:0] in_tile;

    logic [ADDR_W-1:0] addr_mem_q [2][DEPTH];
    logic [TILE_W-1:0] tile_mem_q [2][DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [1:0][PW-1:0] wptr_q, wptr_d;
    logic [1:0][PW-1:0] rptr_q, rptr_d;

    logic [1:0] empty;
    logic [1:0] full;
    logic [1:0] gnt;
    logic [1:0] pop;
    logic [1:0] push;
    logic [1:0] drop;
    logic       load;

    logic              last_q, last_d;
    logic [1:0]        ovf_q, ovf_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic              src_q, src_d;

    assign in_valid = {pe1_valid_i, pe0_valid_i};
    assign in_addr  = {pe1_addr_i, pe0_addr_i};
    assign in_tile  = {pe1_tile_i, pe0_tile_i};

    always_comb begin
        empty = '0;
        full  = '0;
        for (int s = 0; s < 2; s++) begin
            empty[s] = (wptr_q[s] == rptr_q[s]);
            full[s]  = (wptr_q[s][AW-1:0] == rptr_q[s][AW-1:0])
                    && (wptr_q[s][AW] != rptr_q[s][AW]);
        end
    end

    always_comb begin
        load   = (state_q == ST_EMPTY) || mem_ready_i;
        // last_q names the source granted most recently; on a tie the
        // other one wins.
        gnt[0] = !empty[0] && (empty[1] || last_q);
        gnt[1] = !empty[1] && (empty[0] || !last_q);
        pop    = load ? gnt : 2'b00;
        // A full FIFO still takes a push when its head leaves this cycle.
        push   = in_valid & (~full | pop);
        drop   = in_valid & full & ~pop;
        ovf_d  = ovf_q | drop;

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        for (int s = 0; s < 2; s++) begin
            wptr_d[s] = wptr_q[s] + PW'(push[s]);
            rptr_d[s] = rptr_q[s] + PW'(pop[s]);
        end

        state_d = state_q;
        addr_d  = addr_q;
        tile_d  = tile_q;
        src_d   = src_q;
        last_d  = last_q;
        if (load) begin
            unique case (1'b1)
                gnt[0]: begin
                    state_d = ST_HOLD;
                    addr_d  = addr_mem_q[0][rptr_q[0][AW-1:0]];
                    tile_d  = tile_mem_q[0][rptr_q[0][AW-1:0]];
                    src_d   = 1'b0;
                    last_d  = 1'b0;
                end
                gnt[1]: begin
                    state_d = ST_HOLD;
                    addr_d  = addr_mem_q[1][rptr_q[1][AW-1:0]];
                    tile_d  = tile_mem_q[1][rptr_q[1][AW-1:0]];
                    src_d   = 1'b1;
                    last_d  = 1'b1;
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Storage has no reset; pointer reset alone discards contents.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                addr_mem_q[s][wptr_q[s][AW-1:0]] <= in_addr[s];
                tile_mem_q[s][wptr_q[s][AW-1:0]] <= in_tile[s];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            wptr_q  <= '0;
            rptr_q  <= '0;
            last_q  <= 1'b1;
            ovf_q   <= '0;
            addr_q  <= '0;
            tile_q  <= '0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            addr_q  <= addr_d;
            tile_q  <= tile_d;
            src_q   <= src_d;
        end
    end

    assign mem_valid_o = (state_q == ST_HOLD);
    assign mem_addr_o  = addr_q;
    assign mem_tile_o  = tile_q;
    assign mem_src_o   = src_q;
    assign ovf_o       = ovf_q;
    assign idle_o      = (&empty) && (state_q == ST_EMPTY);

`ifdef CIM_RESULT_ARB_STATS_EN
    logic        acc;
    logic [15:0] wr_cnt0_q, wr_cnt0_d;
    logic [15:0] wr_cnt1_q, wr_cnt1_d;

    always_comb begin
        acc       = (state_q == ST_HOLD) && mem_ready_i;
        wr_cnt0_d = wr_cnt0_q + 16'(acc && !src_q);
        wr_cnt1_d = wr_cnt1_q + 16'(acc && src_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt0_q <= '0;
            wr_cnt1_q <= '0;
        end else begin
            wr_cnt0_q <= wr_cnt0_d;
            wr_cnt1_q <= wr_cnt1_d;
        end
    end

    assign wr_cnt0_o = wr_cnt0_q;
    assign wr_cnt1_o = wr_cnt1_q;
`else
    assign wr_cnt0_o = '0;
    assign wr_cnt1_o = '0;
`endif

endmodule

// File: tb/tb_cim_result_arbiter.sv
// tb_cim_result_arbiter: directed and random stimulus for cim_result_arbiter,
// checked every cycle against a queue-level reference model.
module tb_cim_result_arbiter;

    localparam int TW = 432;
    localparam int AW = 8;
    localparam int DP = 4;

`ifdef CIM_RESULT_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pe0_valid_i = 1'b0;
    logic [AW-1:0] pe0_addr_i = '0;
    logic [TW-1:0] pe0_tile_i = '0;
    logic          pe1_valid_i = 1'b0;
    logic [AW-1:0] pe1_addr_i = '0;
    logic [TW-1:0] pe1_tile_i = '0;
    logic          mem_valid_o;
    logic          mem_ready_i = 1'b0;
    logic [AW-1:0] mem_addr_o;
    logic [TW-1:0] mem_tile_o;
    logic          mem_src_o;
    logic [1:0]    ovf_o;
    logic          idle_o;
    logic [15:0]   wr_cnt0_o;
    logic [15:0]   wr_cnt1_o;

    cim_result_arbiter #(
        .TILE_W(TW),
        .ADDR_W(AW),
        .DEPTH (DP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pe0_valid_i(pe0_valid_i),
        .pe0_addr_i (pe0_addr_i),
        .pe0_tile_i (pe0_tile_i),
        .pe1_valid_i(pe1_valid_i),
        .pe1_addr_i (pe1_addr_i),
        .pe1_tile_i (pe1_tile_i),
        .mem_valid_o(mem_valid_o),
        .mem_ready_i(mem_ready_i),
        .mem_addr_o (mem_addr_o),
        .mem_tile_o (mem_tile_o),
        .mem_src_o  (mem_src_o),
        .ovf_o      (ovf_o),
        .idle_o     (idle_o),
        .wr_cnt0_o  (wr_cnt0_o),
        .wr_cnt1_o  (wr_cnt1_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [TW-1:0] t;
    } ent_t;

    // Reference model state
    ent_t        q0[$];
    ent_t        q1[$];
    bit          hv;
    bit          hs;
    ent_t        he;
    bit          last;
    logic [1:0]  movf;
    logic [15:0] c0, c1;

    int          checks = 0;
    int          failures = 0;
    logic [AW-1:0] wr_log[$];

    task automatic chk(input string tag, input logic [TW-1:0] got,
                       input logic [TW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] rnd_tile();
        logic [447:0] r;
        for (int i = 0; i < 14; i++) r[i*32 +: 32] = $urandom;
        return r[TW-1:0];
    endfunction

    function automatic logic [TW-1:0] const_tile(input logic [11:0] v);
        logic [TW-1:0] r;
        for (int k = 0; k < 36; k++) r[k*12 +: 12] = v;
        return r;
    endfunction

    task automatic model_clear();
        q0.delete();
        q1.delete();
        hv   = 1'b0;
        hs   = 1'b0;
        he   = '0;
        last = 1'b1;
        movf = '0;
        c0   = '0;
        c1   = '0;
    endtask

    // One clock edge of the behaviour: a held write leaves on ready, the
    // stage refills from the queues (round-robin on ties), then arrivals
    // join their queue if there is room after the departure.
    task automatic model_step();
        bit   ld;
        ent_t e;
        ld = !hv || mem_ready_i;
        if (hv && mem_ready_i) begin
            if (hs) c1 = c1 + 16'd1;
            else    c0 = c0 + 16'd1;
        end
        if (ld) begin
            if (q0.size() > 0 && (q1.size() == 0 || last)) begin
                he = q0.pop_front(); hs = 1'b0; hv = 1'b1; last = 1'b0;
            end else if (q1.size() > 0) begin
                he = q1.pop_front(); hs = 1'b1; hv = 1'b1; last = 1'b1;
            end else begin
                hv = 1'b0;
            end
        end
        if (pe0_valid_i) begin
            e.a = pe0_addr_i; e.t = pe0_tile_i;
            if (q0.size() < DP) q0.push_back(e);
            else movf[0] = 1'b1;
        end
        if (pe1_valid_i) begin
            e.a = pe1_addr_i; e.t = pe1_tile_i;
            if (q1.size() < DP) q1.push_back(e);
            else movf[1] = 1'b1;
        end
    endtask

    task automatic compare();
        bit idle_e;
        idle_e = (q0.size() == 0) && (q1.size() == 0) && !hv;
        chk("valid", mem_valid_o, hv);
        chk("idle", idle_o, idle_e);
        chk("ovf", ovf_o, movf);
        chk("cnt0", wr_cnt0_o, STATS ? c0 : 16'd0);
        chk("cnt1", wr_cnt1_o, STATS ? c1 : 16'd0);
        if (hv) begin
            chk("addr", mem_addr_o, he.a);
            chk("src", mem_src_o, hs);
            chk("tile", mem_tile_o, he.t);
        end
    endtask

    task automatic cycle(input bit v0, input logic [AW-1:0] a0,
                         input logic [TW-1:0] t0, input bit v1,
                         input logic [AW-1:0] a1, input logic [TW-1:0] t1,
                         input bit rdy);
        pe0_valid_i = v0; pe0_addr_i = a0; pe0_tile_i = t0;
        pe1_valid_i = v1; pe1_addr_i = a1; pe1_tile_i = t1;
        mem_ready_i = rdy;
        #1;
        if (mem_valid_o && mem_ready_i) wr_log.push_back(mem_addr_o);
        @(posedge clk);
        model_step();
        #1 compare();
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0, rdy);
    endtask

    // Called at a negedge; reset is held across one rising edge.
    task automatic do_reset();
        pe0_valid_i = 1'b0;
        pe1_valid_i = 1'b0;
        mem_ready_i = 1'b0;
        reset = 1'b0;
        #1;
        model_clear();
        chk("rst_valid", mem_valid_o, 1'b0);
        chk("rst_idle", idle_o, 1'b1);
        chk("rst_ovf", ovf_o, 2'b00);
        chk("rst_addr", mem_addr_o, '0);
        chk("rst_tile", mem_tile_o, '0);
        chk("rst_src", mem_src_o, 1'b0);
        chk("rst_cnt0", wr_cnt0_o, 16'd0);
        chk("rst_cnt1", wr_cnt1_o, 16'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    int tie_exp[6] = '{0, 10, 1, 11, 2, 12};
    int pv0, pv1, prdy;

    initial begin
        model_clear();
        @(negedge clk);
        do_reset();

        // Single write
        cycle(1, 8'h05, const_tile(12'd3), 0, '0, '0, 1);
        cycle(0, '0, '0, 0, '0, '0, 1);
        chk("single_valid", mem_valid_o, 1'b1);
        chk("single_addr", mem_addr_o, 8'h05);
        chk("single_src", mem_src_o, 1'b0);
        chk("single_tile", mem_tile_o, const_tile(12'd3));
        cycle(0, '0, '0, 0, '0, '0, 1);
        chk("single_idle", idle_o, 1'b1);

        // Tie round-robin
        do_reset();
        wr_log.delete();
        for (int i = 0; i < 3; i++)
            cycle(1, AW'(i), rnd_tile(), 1, AW'(10 + i), rnd_tile(), 1);
        idle_cycles(6, 1);
        chk("tie_count", wr_log.size(), 6);
        for (int i = 0; i < 6 && i < wr_log.size(); i++)
            chk("tie_order", wr_log[i], AW'(tie_exp[i]));

        // Stall and overflow on source 1
        do_reset();
        for (int i = 0; i < 5; i++)
            cycle(0, '0, '0, 1, AW'(20 + i), rnd_tile(), 0);
        chk("stall_noovf", ovf_o, 2'b00);
        cycle(0, '0, '0, 1, 8'd25, rnd_tile(), 0);
        chk("stall_ovf", ovf_o, 2'b10);
        wr_log.delete();
        idle_cycles(8, 1);
        chk("stall_count", wr_log.size(), 5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++)
            chk("stall_order", wr_log[i], AW'(20 + i));

        // Push onto a full FIFO while it pops
        do_reset();
        for (int i = 0; i < 5; i++)
            cycle(1, AW'(30 + i), rnd_tile(), 0, '0, '0, 0);
        wr_log.delete();
        cycle(1, 8'd35, rnd_tile(), 0, '0, '0, 1);
        chk("fullpop_ovf", ovf_o, 2'b00);
        idle_cycles(8, 1);
        chk("fullpop_count", wr_log.size(), 6);
        for (int i = 0; i < 6 && i < wr_log.size(); i++)
            chk("fullpop_order", wr_log[i], AW'(30 + i));

        // Reset mid-stream
        do_reset();
        for (int i = 0; i < 4; i++)
            cycle(1, AW'(40 + i), rnd_tile(), 0, '0, '0, 0);
        do_reset();
        wr_log.delete();
        idle_cycles(6, 1);
        chk("rst_nostale", wr_log.size(), 0);

        // Write counters
        do_reset();
        for (int i = 0; i < 7; i++)
            cycle(1, AW'(50 + i), rnd_tile(), i < 3, AW'(60 + i),
                  rnd_tile(), 1);
        idle_cycles(6, 1);
        chk("stats_cnt0", wr_cnt0_o, STATS ? 16'd7 : 16'd0);
        chk("stats_cnt1", wr_cnt1_o, STATS ? 16'd3 : 16'd0);

        // Random traffic
        for (int ph = 0; ph < 8; ph++) begin
            if (ph == 4) do_reset();
            pv0  = $urandom_range(0, 100);
            pv1  = $urandom_range(0, 100);
            prdy = $urandom_range(10, 100);
            for (int i = 0; i < 200; i++)
                cycle($urandom_range(0, 99) < pv0, AW'($urandom), rnd_tile(),
                      $urandom_range(0, 99) < pv1, AW'($urandom), rnd_tile(),
                      $urandom_range(0, 99) < prdy);
        end
        idle_cycles(12, 1);
        chk("final_idle", idle_o, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
